// File: rtl/text_console_pkg.sv
// Shared definitions for the text console: FSM states, control codes,
// tram word field layout and a helper that packs one character cell.
package text_console_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CLEAR  = 2'd1,
    ST_SCROLL = 2'd2
  } state_t;

  // Control codes understood by the console
  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SPACE = 8'h20;

  // Field positions inside a tram word (same layout textmode reads)
  localparam int GLYPH_LSB = 0;
  localparam int FG_LSB    = 8;
  localparam int BG_LSB    = 12;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= 8'h20) && (c <= 8'h7E);
  endfunction

  // Low 16 bits of a tram word: {bg, fg, glyph}
  function automatic logic [15:0] cell_word(input logic [7:0] glyph,
                                            input logic [3:0] fg,
                                            input logic [3:0] bg);
    logic [15:0] w;
    w = '0;
    w[GLYPH_LSB +: 8] = glyph;
    w[FG_LSB +: 4]    = fg;
    w[BG_LSB +: 4]    = bg;
    return w;
  endfunction

endpackage

// File: rtl/text_console_addr_wrap_add.sv
// Modular address add: y = (a + b) mod DEPTH, valid when a, b < DEPTH,
// so a single conditional subtract is enough.
module addr_wrap_add #(
  parameter int ADDRW = 11,
  parameter int DEPTH = 2016
) (
  input  logic [ADDRW-1:0] a,
  input  logic [ADDRW-1:0] b,
  output logic [ADDRW-1:0] y
);

  logic [ADDRW:0] sum;

  // Add with one extra bit, then fold back into 0..DEPTH-1
  always_comb begin
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= (ADDRW+1)'(DEPTH)) begin
      y = ADDRW'(sum - (ADDRW+1)'(DEPTH));
    end else begin
      y = sum[ADDRW-1:0];
    end
  end

endmodule

// File: rtl/text_console.sv
// Character-stream console owning the tram write port: cursor handling,
// control codes, line wrap, and hardware scrolling by moving scroll_offs
// and blanking the recycled top line.
//
// Handshake: a byte is taken on a rising edge where in_valid && in_ready;
// in_ready is high only in IDLE, and in_data/in_fg/in_bg are don't-care
// whenever in_valid is low.
module text_console
  import text_console_pkg::*;
#(
  parameter int         ADDRW          = 11,
  parameter int         WORD           = 32,
  parameter int         HRES           = 84,
  parameter int         VRES           = 24,
  parameter logic [3:0] DEF_FG         = 4'hF,
  parameter logic [3:0] DEF_BG         = 4'h0,
  parameter logic       CLEAR_ON_RESET = 1'b1
) (
  input  logic             clk_sys,
  input  logic             rst_sys,
  input  logic [7:0]       in_data,
  input  logic [3:0]       in_fg,
  input  logic [3:0]       in_bg,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [3:0]       tram_we,
  output logic [ADDRW-1:0] tram_addr,
  output logic [WORD-1:0]  tram_din,
  output logic [ADDRW-1:0] scroll_offs,
  output logic [ADDRW-1:0] cursor_x,
  output logic [ADDRW-1:0] cursor_y,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  localparam int DEPTH = HRES * VRES;

  localparam logic [ADDRW-1:0] ONE     = ADDRW'(1);
  localparam logic [ADDRW-1:0] H_A     = ADDRW'(HRES);
  localparam logic [ADDRW-1:0] LAST_X  = ADDRW'(HRES - 1);
  localparam logic [ADDRW-1:0] LAST_Y  = ADDRW'(VRES - 1);
  localparam logic [ADDRW-1:0] DEPTH_A = ADDRW'(DEPTH);

  state_t           state, state_n;
  logic [ADDRW-1:0] line_base, line_base_n;
  logic [ADDRW-1:0] cnt, cnt_n;
  logic [3:0]       fill_fg, fill_fg_n;
  logic [3:0]       fill_bg, fill_bg_n;
  logic [ADDRW-1:0] cursor_x_n, cursor_y_n, scroll_offs_n;
  logic [3:0]       we_n;
  logic [ADDRW-1:0] addr_n;
  logic [WORD-1:0]  din_n;
  logic             ready_n, busy_n;
  logic             accept, do_newline;

  // Adder operands and results
  logic [ADDRW-1:0] x_sel, cell_addr, line_next, scroll_next, fill_addr;

  // Backspace writes at the column it moves back to
  always_comb begin
    x_sel = (in_data == CH_BS) ? (cursor_x - ONE) : cursor_x;
  end

  addr_wrap_add #(.ADDRW(ADDRW), .DEPTH(DEPTH)) u_cell (
    .a(line_base), .b(x_sel), .y(cell_addr));

  addr_wrap_add #(.ADDRW(ADDRW), .DEPTH(DEPTH)) u_line (
    .a(line_base), .b(H_A), .y(line_next));

  addr_wrap_add #(.ADDRW(ADDRW), .DEPTH(DEPTH)) u_scroll (
    .a(scroll_offs), .b(H_A), .y(scroll_next));

  addr_wrap_add #(.ADDRW(ADDRW), .DEPTH(DEPTH)) u_fill (
    .a(scroll_offs), .b(cnt), .y(fill_addr));

  assign dbg_state = state;

  // Next-state and next-output decode for the IDLE/CLEAR/SCROLL machine
  always_comb begin
    state_n       = state;
    line_base_n   = line_base;
    cnt_n         = cnt;
    fill_fg_n     = fill_fg;
    fill_bg_n     = fill_bg;
    cursor_x_n    = cursor_x;
    cursor_y_n    = cursor_y;
    scroll_offs_n = scroll_offs;
    we_n          = 4'b0000;
    addr_n        = tram_addr;
    din_n         = tram_din;
    accept        = in_valid && in_ready;
    do_newline    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (is_printable(in_data)) begin
            we_n   = 4'b1111;
            addr_n = cell_addr;
            din_n  = {{(WORD-16){1'b0}}, cell_word(in_data, in_fg, in_bg)};
            if (cursor_x == LAST_X) begin
              do_newline = 1'b1;
            end else begin
              cursor_x_n = cursor_x + ONE;
            end
          end else begin
            case (in_data)
              CH_LF: do_newline = 1'b1;
              CH_CR: cursor_x_n = '0;
              CH_BS: begin
                if (cursor_x != '0) begin
                  cursor_x_n = cursor_x - ONE;
                  we_n       = 4'b1111;
                  addr_n     = cell_addr;
                  din_n      = {{(WORD-16){1'b0}}, cell_word(CH_SPACE, in_fg, in_bg)};
                end
              end
              CH_FF: begin
                state_n   = ST_CLEAR;
                cnt_n     = '0;
                fill_fg_n = in_fg;
                fill_bg_n = in_bg;
              end
              default: ;
            endcase
          end

          // Line feed or wrap: step down, or recycle the top line
          if (do_newline) begin
            cursor_x_n = '0;
            if (cursor_y != LAST_Y) begin
              cursor_y_n  = cursor_y + ONE;
              line_base_n = line_next;
            end else begin
              state_n   = ST_SCROLL;
              cnt_n     = '0;
              fill_fg_n = in_fg;
              fill_bg_n = in_bg;
            end
          end
        end
      end

      ST_SCROLL: begin
        if (cnt == H_A) begin
          // Old top line becomes the new bottom (cursor) line
          state_n       = ST_IDLE;
          scroll_offs_n = scroll_next;
          line_base_n   = scroll_offs;
        end else begin
          we_n   = 4'b1111;
          addr_n = fill_addr;
          din_n  = {{(WORD-16){1'b0}}, cell_word(CH_SPACE, fill_fg, fill_bg)};
          cnt_n  = cnt + ONE;
        end
      end

      ST_CLEAR: begin
        if (cnt == DEPTH_A) begin
          state_n       = ST_IDLE;
          scroll_offs_n = '0;
          line_base_n   = '0;
          cursor_x_n    = '0;
          cursor_y_n    = '0;
        end else begin
          we_n   = 4'b1111;
          addr_n = cnt;
          din_n  = {{(WORD-16){1'b0}}, cell_word(CH_SPACE, fill_fg, fill_bg)};
          cnt_n  = cnt + ONE;
        end
      end

      default: state_n = ST_IDLE;
    endcase

    ready_n = (state_n == ST_IDLE);
    busy_n  = (state_n != ST_IDLE);
  end

  // State and all registered outputs; reset wins over everything
  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      state       <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
      line_base   <= '0;
      cnt         <= '0;
      fill_fg     <= DEF_FG;
      fill_bg     <= DEF_BG;
      cursor_x    <= '0;
      cursor_y    <= '0;
      scroll_offs <= '0;
      tram_we     <= 4'b0000;
      tram_addr   <= '0;
      tram_din    <= '0;
      in_ready    <= ~CLEAR_ON_RESET;
      busy        <= CLEAR_ON_RESET;
    end else begin
      state       <= state_n;
      line_base   <= line_base_n;
      cnt         <= cnt_n;
      fill_fg     <= fill_fg_n;
      fill_bg     <= fill_bg_n;
      cursor_x    <= cursor_x_n;
      cursor_y    <= cursor_y_n;
      scroll_offs <= scroll_offs_n;
      tram_we     <= we_n;
      tram_addr   <= addr_n;
      tram_din    <= din_n;
      in_ready    <= ready_n;
      busy        <= busy_n;
    end
  end

endmodule
